// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
//
// Issue/writeback controller in front of the slow iterative multiply/divide
// unit. It accepts one MUL/DIV request at a time from ID and registers the
// operands. The unit enables are held stable until the unit reports
// completion. The captured result is then offered to writeback.
//
// A one-entry last-result cache returns a repeated identical operation
// without relaunching the unit. A flush during an operation cannot simply
// drop the enables, because the unit only advances while it is enabled. The
// operation is therefore drained: the enables stay up until the unit signals
// valid, and that result is discarded.
//
// Parameters
//   CACHE_EN           1 enables the last-result cache, 0 always launches
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/_o     request handshake from ID (req_ready_o is an output)
//   req_operator_i     0=MULL 1=MULH 2=DIV 3=REM
//   req_signed_mode_i  bit0 op_a signed, bit1 op_b signed
//   req_op_a_i/_b_i    operands
//   flush_i            kill any accepted or pending transaction
//   mult_en_o/div_en_o enables to the unit
//   operator_o, signed_mode_o, op_a_o, op_b_o  registered operation to unit
//   md_valid_i         single-cycle result strobe from the unit
//   md_result_i        unit result
//   rsp_valid_o/rsp_ready_i  result handshake to writeback
//   rsp_result_o       result (0 when no response is pending)
module md_issue_ctrl #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_operator_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        flush_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;

  logic [1:0]  operator_q;
  logic [1:0]  signed_mode_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [31:0] result_q;

  logic        cache_valid_q;
  logic [1:0]  cache_operator_q;
  logic [1:0]  cache_signed_mode_q;
  logic [31:0] cache_op_a_q;
  logic [31:0] cache_op_b_q;
  logic [31:0] cache_result_q;

  logic        accept;
  logic        cache_hit;
  logic        md_capture;
  logic        unit_active;

  assign accept = req_valid_i & req_ready_o;

  // A hit needs every field of the incoming request to match the tag, so
  // that signedness differences never alias to a stale result.
  assign cache_hit = CACHE_EN && cache_valid_q
                     && (req_operator_i    == cache_operator_q)
                     && (req_signed_mode_i == cache_signed_mode_q)
                     && (req_op_a_i        == cache_op_a_q)
                     && (req_op_b_i        == cache_op_b_q);

  // A result is only kept when it arrives for a live operation. A
  // simultaneous flush discards it and leaves the cache untouched.
  assign md_capture = (state_q == BUSY) & md_valid_i & ~flush_i;

  // The unit stays enabled while it works for us, including the drain after
  // a flush.
  assign unit_active = (state_q == BUSY) || (state_q == DRAIN);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = cache_hit ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (md_valid_i) begin
          state_d = flush_i ? IDLE : DONE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (md_valid_i) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (rsp_ready_i || flush_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Nothing on the response side looks at md_valid_i or
  // md_result_i directly; the result always passes through result_q.
  always_comb begin
    req_ready_o  = (state_q == IDLE) && !flush_i;
    mult_en_o    = unit_active && !operator_q[1];
    div_en_o     = unit_active &&  operator_q[1];
    rsp_valid_o  = (state_q == DONE);
    rsp_result_o = (state_q == DONE) ? result_q : 32'd0;
  end

  assign operator_o    = operator_q;
  assign signed_mode_o = signed_mode_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;

  // Operation, result and cache registers. The operation registers change
  // only on accept, so they stay stable for the whole operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      operator_q          <= 2'd0;
      signed_mode_q       <= 2'd0;
      op_a_q              <= 32'd0;
      op_b_q              <= 32'd0;
      result_q            <= 32'd0;
      cache_valid_q       <= 1'b0;
      cache_operator_q    <= 2'd0;
      cache_signed_mode_q <= 2'd0;
      cache_op_a_q        <= 32'd0;
      cache_op_b_q        <= 32'd0;
      cache_result_q      <= 32'd0;
    end else begin
      if (accept) begin
        operator_q    <= req_operator_i;
        signed_mode_q <= req_signed_mode_i;
        op_a_q        <= req_op_a_i;
        op_b_q        <= req_op_b_i;
        if (cache_hit) begin
          result_q <= cache_result_q;
        end
      end
      if (md_capture) begin
        result_q            <= md_result_i;
        cache_valid_q       <= 1'b1;
        cache_operator_q    <= operator_q;
        cache_signed_mode_q <= signed_mode_q;
        cache_op_a_q        <= op_a_q;
        cache_op_b_q        <= op_b_q;
        cache_result_q      <= md_result_i;
      end
    end
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue/writeback controller directly upstream of the slow iterative multiply/divide unit.
- Accepts one MUL/DIV request per transaction from the ID stage over a valid/ready handshake, registers the operands and holds the unit's enables stable until the unit signals completion.
- Captures the result and presents it to writeback over a second valid/ready handshake.
- A one-entry last-result cache returns repeated identical operations without relaunching the unit. Flushes are handled safely by draining the in-flight operation.

Parameters:
CACHE_EN, 1, 1 enables the last-result cache; 0 always launches the unit.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  ID stage presents a request
req_ready_o  out  1  request accepted when req_valid_i & req_ready_o
req_operator_i  in  2  0=MULL, 1=MULH, 2=DIV, 3=REM
req_signed_mode_i  in  2  bit0 op_a signed, bit1 op_b signed
req_op_a_i  in  32  operand A
req_op_b_i  in  32  operand B
flush_i  in  1  kill any accepted or pending transaction
mult_en_o  out  1  multiply enable to unit
div_en_o  out  1  divide enable to unit
operator_o  out  2  registered operator to unit
signed_mode_o  out  2  registered signed mode to unit
op_a_o  out  32  registered operand A to unit
op_b_o  out  32  registered operand B to unit
md_valid_i  in  1  unit result valid, single cycle
md_result_i  in  32  unit result
rsp_valid_o  out  1  result available to writeback
rsp_ready_i  in  1  writeback consumes result
rsp_result_o  out  32  result

Behaviour:
- FSM states: IDLE, BUSY, DONE, DRAIN. Reset state is IDLE.
- Reset values:
  - All registers 0 and cache invalid.
  - req_ready_o = 1 (IDLE, flush_i low).
  - mult_en_o, div_en_o, rsp_valid_o = 0.
  - operator_o, signed_mode_o, op_a_o, op_b_o, rsp_result_o = 0.
- req_ready_o = (state==IDLE) & ~flush_i, purely combinational. While req_ready_o is low, the request is not accepted and must be held by the ID stage.
- IDLE, on accept:
  - Register operator, signed mode, op_a and op_b.
  - Cache hit: CACHE_EN, cache valid, and all four fields equal the cached tag. Load result_q from the cache and go to DONE. Enables are never asserted.
  - Otherwise go to BUSY.
- BUSY:
  - mult_en_o = operator_q in {0,1}; div_en_o = operator_q in {2,3}.
  - operator_o, signed_mode_o, op_a_o and op_b_o are driven from registers and stay stable for the whole operation.
  - md_valid_i & ~flush_i: result_q <= md_result_i, cache tag/data <= current operation, cache valid <= 1, go to DONE. The enable drops in the next cycle, which matches the unit returning to its idle state after valid.
  - flush_i without md_valid_i: go to DRAIN.
  - flush_i together with md_valid_i: discard the result, leave the cache unchanged, go to IDLE.
- DRAIN:
  - Enables stay asserted with the same operands, because the unit only advances while enabled and must reach its idle state.
  - req_ready_o = 0 and rsp_valid_o = 0.
  - On md_valid_i: discard the result, leave the cache unchanged, go to IDLE.
  - Further flush_i has no additional effect.
- DONE:
  - rsp_valid_o = 1 and rsp_result_o = result_q, held stable until rsp_ready_i.
  - rsp_ready_i: go to IDLE.
  - flush_i (with or without rsp_ready_i): drop the response and go to IDLE. The cache keeps any valid entry.
- Latency from accept to rsp_valid_o:
  - Cache hit: 1 cycle.
  - Miss: unit latency + 1 (unit valid cycle → DONE next cycle).
- rsp_result_o = 0 outside DONE. Enables are 0 in IDLE and DONE.
- Reset mid-operation returns everything to reset values immediately and invalidates the cache. The unit is reset by the same rst_ni.
- No combinational path from md_valid_i or md_result_i to rsp_*.

Test Plan:
1. Reset, then MULL a=3, b=5, unsigned → mult_en_o held high until md_valid_i; rsp_valid_o one cycle later with 0x0000000F; div_en_o never high.
2. DIV a=100, b=7, signed_mode=3 → result 14. Repeat the identical request → rsp_valid_o 1 cycle after accept with 14 and no enable asserted. Then REM with the same operands → miss, result 2.
3. DIV 0x80000000 / 3 signed, assert flush_i mid-BUSY → DRAIN with div_en_o held until md_valid_i; no rsp_valid_o; req_ready_o low throughout. Next identical request misses the cache.
4. MULH a=0xFFFFFFFF, b=2 signed with rsp_ready_i low for 5 cycles → rsp_valid_o and 0xFFFFFFFF held stable; req_ready_o stays 0 until the handshake completes.
5. rst_ni pulsed low during BUSY → all outputs to reset values asynchronously; a subsequent repeat of the prior completed request misses the cache.
6. CACHE_EN=0: two identical MULL 7×6 requests → both launch the unit, both return 42.
